// File: rtl/scanner_pkg.sv
// Shared types and helpers for the truth-table scanner.
package scanner_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSample,
    StDone
  } state_e;

  // Settle counter width; covers SETTLE up to 15.
  localparam int unsigned CntW = 4;

  // Number of minterms for an n-input function.
  function automatic int unsigned pow2(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Scanner bundle: host control/readout plus the function-under-test hookup.
// master = host/bench side, slave = scanner side.
interface truth_table_scanner_if
  import scanner_pkg::*;
#(
  parameter int unsigned N_IN = 4
);

  logic                     start;
  logic                     abort;
  logic                     busy;
  logic                     done;
  logic [N_IN-1:0]          dut_in;
  logic                     dut_y;
  logic [pow2(N_IN)-1:0]    tbl;
  logic [N_IN:0]            ones;

  modport master (
    output start, abort, dut_y,
    input  busy, done, dut_in, tbl, ones
  );

  modport slave (
    input  start, abort, dut_y,
    output busy, done, dut_in, tbl, ones
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; zero flags the end of a vector's settle window.
module settle_timer
  import scanner_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            en,
  output logic            zero
);

  logic [CntW-1:0] cnt_q;

  // Count down while enabled, saturating at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input minterm of a combinational function in ascending order,
// holding each for SETTLE+1 cycles, and records the truth table and 1-count.
module truth_table_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic                 clk,
  input logic                 reset,
  truth_table_scanner_if.slave bus
);

  localparam int unsigned NVec = pow2(N_IN);
  // HOLD lasts SETTLE cycles, so the timer starts at SETTLE-1.
  localparam logic [CntW-1:0] LoadVal = (SETTLE == 0) ? '0 : CntW'(SETTLE - 1);
  // With no settle time each vector goes straight to SAMPLE.
  localparam state_e VecSt = (SETTLE == 0) ? StSample : StHold;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [NVec-1:0] tbl_q, tbl_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            tmr_load;
  logic            tmr_zero;
  logic            busy;

  settle_timer u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (LoadVal),
    .en       (state_q == StHold),
    .zero     (tmr_zero)
  );

  // State, index and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tbl_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      ones_q  <= ones_d;
    end
  end

  // Next-state: start/abort handling, per-vector sampling and index advance.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tbl_d    = tbl_q;
    ones_d   = ones_q;
    tmr_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          tbl_d    = '0;
          ones_d   = '0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = VecSt;
        end
      end
      StHold: begin
        if (bus.abort) begin
          tbl_d   = '0;
          ones_d  = '0;
          idx_d   = '0;
          state_d = StIdle;
        end else if (tmr_zero) begin
          state_d = StSample;
        end
      end
      StSample: begin
        // Abort wins over the sample taken in the same cycle.
        if (bus.abort) begin
          tbl_d   = '0;
          ones_d  = '0;
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          tbl_d[idx_q] = bus.dut_y;
          ones_d       = ones_q + {{N_IN{1'b0}}, bus.dut_y};
          if (idx_q == {N_IN{1'b1}}) begin
            state_d = StDone;
          end else begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
            state_d  = VecSt;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state; dut_in is parked at 0 when idle.
  always_comb begin
    busy       = (state_q == StHold) || (state_q == StSample);
    bus.busy   = busy;
    bus.done   = (state_q == StDone);
    bus.dut_in = busy ? idx_q : '0;
    bus.tbl    = tbl_q;
    bus.ones   = ones_q;
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: four scanner configurations side by side, each driving
// its own reference function; scan results go through an expectation queue.
module tb_truth_table_scanner;

  localparam int NCfg = 4;

  // cfg0: N=4 S=0 minterm set; cfg1: N=4 S=2 f=1; cfg2: N=4 S=1 f=a; cfg3: N=2 S=0 XOR
  function automatic int cfg_nin(input int g);
    return (g == 3) ? 2 : 4;
  endfunction

  function automatic int cfg_settle(input int g);
    case (g)
      0:       return 0;
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_y(input int g, input logic [5:0] v);
    case (g)
      0:       return (v inside {6'd0, 6'd1, 6'd2, 6'd4, 6'd8, 6'd12, 6'd14, 6'd15});
      1:       return 1'b1;
      2:       return v[3];
      default: return v[1] ^ v[0];
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        start_r [NCfg];
  logic        abort_r [NCfg];
  logic        busy_w  [NCfg];
  logic        done_w  [NCfg];
  logic [5:0]  din_w   [NCfg];
  logic [63:0] tbl_w   [NCfg];
  logic [6:0]  ones_w  [NCfg];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCfg; g++) begin : g_cfg
    localparam int unsigned NI = cfg_nin(g);
    localparam int unsigned ST = cfg_settle(g);

    truth_table_scanner_if #(.N_IN(NI)) bus ();

    assign bus.start = start_r[g];
    assign bus.abort = abort_r[g];
    assign bus.dut_y = model_y(g, 6'(bus.dut_in));
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign din_w[g]  = 6'(bus.dut_in);
    assign tbl_w[g]  = 64'(bus.tbl);
    assign ones_w[g] = 7'(bus.ones);

    truth_table_scanner #(.N_IN(NI), .SETTLE(ST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  typedef struct {
    int          cfg;
    logic [63:0] tbl;
    int          ones;
    int          done_cyc;
    int          extra_start;
  } vec_t;

  vec_t vecs [5];
  vec_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string name, input int g);
    check({name, "_ctl"}, 64'({busy_w[g], done_w[g], din_w[g], ones_w[g]}), 64'd0);
    check({name, "_tbl"}, tbl_w[g], 64'd0);
  endtask

  // One full scan; start is pushed on the queue, popped and compared at done.
  task automatic run_scan(input vec_t v);
    int   g;
    int   st;
    int   got_done;
    int   din_bad;
    int   busy_bad;
    vec_t e;
    logic [63:0] tbl_at_done;
    g        = v.cfg;
    st       = cfg_settle(g);
    got_done = -1;
    din_bad  = 0;
    busy_bad = 0;
    exp_q.push_back(v);
    start_r[g] = 1'b1;
    tick();
    start_r[g] = 1'b0;
    for (int c = 0; c < v.done_cyc + 8; c++) begin
      if (din_w[g] !== 6'(c / (st + 1))) din_bad++;
      if (busy_w[g] !== 1'b1) busy_bad++;
      start_r[g] = (c == v.extra_start);
      tick();
      if (done_w[g] === 1'b1) begin
        got_done = c + 1;
        break;
      end
    end
    start_r[g] = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("cfg%0d_done_cycle", g), 64'(got_done), 64'(e.done_cyc));
    check($sformatf("cfg%0d_din_seq_errs", g), 64'(din_bad), 64'd0);
    check($sformatf("cfg%0d_busy_errs", g), 64'(busy_bad), 64'd0);
    check($sformatf("cfg%0d_busy_at_done", g), 64'(busy_w[g]), 64'd0);
    check($sformatf("cfg%0d_table", g), tbl_w[g], e.tbl);
    check($sformatf("cfg%0d_ones", g), 64'(ones_w[g]), 64'(e.ones));
    tbl_at_done = tbl_w[g];
    tick();
    check($sformatf("cfg%0d_done_pulse_len", g), 64'(done_w[g]), 64'd0);
    check($sformatf("cfg%0d_table_hold", g), tbl_w[g], tbl_at_done);
    check($sformatf("cfg%0d_din_after", g), 64'(din_w[g]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int done_seen;

    for (int g = 0; g < NCfg; g++) begin
      start_r[g] = 1'b0;
      abort_r[g] = 1'b0;
    end
    reset = 1'b1;

    // cfg, table, ones, done cycle, cycle at which a stray start is pulsed
    vecs[0] = '{cfg: 0, tbl: 64'hD117, ones: 8,  done_cyc: 16, extra_start: -1};
    vecs[1] = '{cfg: 1, tbl: 64'hFFFF, ones: 16, done_cyc: 48, extra_start: -1};
    vecs[2] = '{cfg: 2, tbl: 64'hFF00, ones: 8,  done_cyc: 32, extra_start: 10};
    vecs[3] = '{cfg: 3, tbl: 64'h6,    ones: 2,  done_cyc: 4,  extra_start: -1};
    vecs[4] = '{cfg: 3, tbl: 64'h6,    ones: 2,  done_cyc: 4,  extra_start: -1};

    tick();
    tick();
    for (int g = 0; g < NCfg; g++) check_idle_zero($sformatf("reset_cfg%0d", g), g);
    reset = 1'b0;
    tick();

    // Reset mid-scan: cfg2 at vector 7 while cfg0 has accumulated results.
    start_r[0] = 1'b1;
    start_r[2] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    start_r[2] = 1'b0;
    cnt = 0;
    while (din_w[2] !== 6'd7 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("rst_reach_vec7", 64'(din_w[2]), 64'd7);
    // cfg0 has sampled minterms 0..13 by now: {0,1,2,4,8,12} are ones.
    check("rst_cfg0_partial_ones", 64'(ones_w[0]), 64'd6);
    #2;
    reset = 1'b1;
    #1;
    check_idle_zero("rst_async_cfg2", 2);
    check_idle_zero("rst_async_cfg0", 0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_w[0] === 1'b1 || done_w[2] === 1'b1 || busy_w[2] !== 1'b0) done_seen++;
    end
    check("rst_no_done_no_busy", 64'(done_seen), 64'd0);

    // Table-driven full scans; the last two are back-to-back at minimum spacing.
    for (int i = 0; i < 5; i++) run_scan(vecs[i]);

    // Abort at idx 5 on cfg1 (f=1, so partial results are non-zero).
    start_r[1] = 1'b1;
    tick();
    start_r[1] = 1'b0;
    cnt = 0;
    while (din_w[1] !== 6'd5 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("abort_reach_idx5", 64'(din_w[1]), 64'd5);
    check("abort_partial_ones", 64'(ones_w[1]), 64'd5);
    abort_r[1] = 1'b1;
    tick();
    abort_r[1] = 1'b0;
    check_idle_zero("abort_cleared", 1);
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done_w[1] === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // start and abort together in IDLE: abort wins.
    start_r[1] = 1'b1;
    abort_r[1] = 1'b1;
    tick();
    start_r[1] = 1'b0;
    abort_r[1] = 1'b0;
    check("start_abort_busy", 64'(busy_w[1]), 64'd0);
    tick();
    check("start_abort_busy_later", 64'(busy_w[1]), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
